// File: rtl/xgxs_pkg.sv
// Shared character constants, state/column enums and PRBS7 helpers for the
// XGXS transmit idle sequencer.
package xgxs_pkg;

    localparam logic [7:0] CH_I = 8'h07;
    localparam logic [7:0] CH_S = 8'hFB;
    localparam logic [7:0] CH_T = 8'hFD;
    localparam logic [7:0] CH_Q = 8'h9C;
    localparam logic [7:0] CH_E = 8'hFE;
    localparam logic [7:0] CH_K = 8'hBC;
    localparam logic [7:0] CH_R = 8'h1C;
    localparam logic [7:0] CH_A = 8'h7C;

    // x^7 + x^6 + 1: feedback from bits 6 and 5
    localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA_COL = 2'd1,
        TERM     = 2'd2,
        OTHER    = 2'd3
    } col_type_t;

    function automatic logic [6:0] prbs7_next(input logic [6:0] cur);
        return {cur[5:0], ^(cur & PRBS7_TAPS)};
    endfunction

    // Control characters that travel to the encoder unchanged
    function automatic logic is_pass_ctrl(input logic [7:0] b);
        return (b == CH_S) || (b == CH_T) || (b == CH_Q) || (b == CH_E);
    endfunction

endpackage

// File: rtl/xgxs_prbs7.sv
// Seven-bit PRBS7 LFSR with advance enable; drives the idle K/R choice and
// the ||A|| spacing.
module xgxs_prbs7
    import xgxs_pkg::*;
#(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    output logic [6:0] prbs
);

    // LFSR register, reloaded with the seed on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prbs <= SEED;
        end else if (advance) begin
            prbs <= prbs7_next(prbs);
        end else begin
            prbs <= prbs;
        end
    end

endmodule

// File: rtl/xgxs_tx_idle_sequencer.sv
// Column controller ahead of four XGXS 8b/10b encoders: startup FSM, idle
// randomisation (||A||/||K||/||R||) and invalid-control mapping to /E/.
module xgxs_tx_idle_sequencer
    import xgxs_pkg::*;
#(
    parameter int         INIT_CYCLES = 16,
    parameter int         A_MIN       = 16,
    parameter logic [6:0] PRBS_SEED   = 7'h7F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] xgmii_txd,
    input  logic [3:0]  xgmii_txc,
    input  logic        tx_enable,
    output logic [31:0] enc_data,
    output logic [3:0]  enc_konstant,
    output logic [1:0]  seq_state,
    output logic        err_col
);

    localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int ACW = $clog2(A_MIN + 16);

    seq_state_t     state_r;
    logic [ICW-1:0] init_cnt_r;
    logic [ACW-1:0] a_cnt_r;
    logic           prev_t_r;

    logic [6:0]     prbs_s;
    logic [3:0]     lane_t_s;
    logic [3:0]     lane_i_s;
    logic           has_t_s;
    logic [1:0]     t_lane_s;
    col_type_t      col_type_s;
    logic [31:0]    nxt_data_s;
    logic [3:0]     nxt_k_s;
    logic           nxt_err_s;
    logic           emit_a_s;

    xgxs_prbs7 #(.SEED(PRBS_SEED)) u_prbs (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (1'b1),
        .prbs    (prbs_s)
    );

    // Column classifier: per-lane /T/ and /I/ flags, first /T/ lane, column type
    always_comb begin
        lane_t_s = 4'h0;
        lane_i_s = 4'h0;
        for (int i = 0; i < 4; i++) begin
            lane_t_s[i] = xgmii_txc[i] && (xgmii_txd[8*i +: 8] == CH_T);
            lane_i_s[i] = xgmii_txd[8*i +: 8] == CH_I;
        end
        has_t_s = |lane_t_s;
        if (lane_t_s[0]) begin
            t_lane_s = 2'd0;
        end else if (lane_t_s[1]) begin
            t_lane_s = 2'd1;
        end else if (lane_t_s[2]) begin
            t_lane_s = 2'd2;
        end else begin
            t_lane_s = 2'd3;
        end
        if ((xgmii_txc == 4'hF) && (lane_i_s == 4'hF)) begin
            col_type_s = IDLE;
        end else if (has_t_s) begin
            col_type_s = TERM;
        end else if (xgmii_txc == 4'h0) begin
            col_type_s = DATA_COL;
        end else begin
            col_type_s = OTHER;
        end
    end

    // Next encoder column; outside DATA the link is held on ||K||
    always_comb begin
        nxt_data_s = {4{CH_K}};
        nxt_k_s    = 4'hF;
        nxt_err_s  = 1'b0;
        emit_a_s   = 1'b0;
        if (state_r == DATA) begin
            case (col_type_s)
                IDLE: begin
                    // ||K|| right after /T/ keeps the end of packet unambiguous
                    if (prev_t_r) begin
                        nxt_data_s = {4{CH_K}};
                    end else if (a_cnt_r == {ACW{1'b0}}) begin
                        nxt_data_s = {4{CH_A}};
                        emit_a_s   = 1'b1;
                    end else if (prbs_s[0]) begin
                        nxt_data_s = {4{CH_K}};
                    end else begin
                        nxt_data_s = {4{CH_R}};
                    end
                end
                DATA_COL: begin
                    nxt_data_s = xgmii_txd;
                    nxt_k_s    = 4'h0;
                end
                default: begin
                    for (int i = 0; i < 4; i++) begin
                        if (!xgmii_txc[i]) begin
                            nxt_data_s[8*i +: 8] = xgmii_txd[8*i +: 8];
                            nxt_k_s[i]           = 1'b0;
                        end else if (is_pass_ctrl(xgmii_txd[8*i +: 8])) begin
                            nxt_data_s[8*i +: 8] = xgmii_txd[8*i +: 8];
                            nxt_k_s[i]           = 1'b1;
                        end else if (lane_i_s[i] && has_t_s && (2'(i) > t_lane_s)) begin
                            nxt_data_s[8*i +: 8] = CH_K;
                            nxt_k_s[i]           = 1'b1;
                        end else begin
                            nxt_data_s[8*i +: 8] = CH_E;
                            nxt_k_s[i]           = 1'b1;
                            nxt_err_s            = 1'b1;
                        end
                    end
                end
            endcase
        end else begin
            nxt_data_s = {4{CH_K}};
            nxt_k_s    = 4'hF;
        end
    end

    // Startup FSM, ||A|| spacing counter, /T/ history and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= INIT;
            init_cnt_r   <= {ICW{1'b0}};
            a_cnt_r      <= ACW'(A_MIN);
            prev_t_r     <= 1'b0;
            enc_data     <= {4{CH_K}};
            enc_konstant <= 4'hF;
            err_col      <= 1'b0;
        end else begin
            enc_data     <= nxt_data_s;
            enc_konstant <= nxt_k_s;
            err_col      <= nxt_err_s;
            prev_t_r     <= (state_r == DATA) && has_t_s;

            if (emit_a_s) begin
                a_cnt_r <= ACW'(A_MIN) + ACW'(prbs_s[3:0]);
            end else if (a_cnt_r != {ACW{1'b0}}) begin
                a_cnt_r <= a_cnt_r - ACW'(1);
            end else begin
                a_cnt_r <= a_cnt_r;
            end

            case (state_r)
                INIT: begin
                    if (init_cnt_r == ICW'(INIT_CYCLES - 1)) begin
                        state_r <= SYNC;
                    end else begin
                        init_cnt_r <= init_cnt_r + ICW'(1);
                    end
                end
                SYNC: begin
                    if (tx_enable) begin
                        state_r <= DATA;
                    end else begin
                        state_r <= SYNC;
                    end
                end
                DATA: begin
                    if (!tx_enable) begin
                        state_r <= SYNC;
                    end else begin
                        state_r <= DATA;
                    end
                end
                default: begin
                    state_r <= INIT;
                end
            endcase
        end
    end

    assign seq_state = state_r;

endmodule

// File: tb/tb_xgxs_tx_idle_sequencer.sv
// Directed bench for the XGXS transmit idle sequencer with an independent
// column/PRBS7 reference for the idle stream.
module tb_xgxs_tx_idle_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] xgmii_txd;
    logic [3:0]  xgmii_txc;
    logic        tx_enable;
    logic [31:0] enc_data;
    logic [3:0]  enc_konstant;
    logic [1:0]  seq_state;
    logic        err_col;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    logic [6:0] m_prbs;
    int         m_acnt;
    int         m_state;
    int         m_icnt;
    bit         m_prevt;

    xgxs_tx_idle_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .xgmii_txd    (xgmii_txd),
        .xgmii_txc    (xgmii_txc),
        .tx_enable    (tx_enable),
        .enc_data     (enc_data),
        .enc_konstant (enc_konstant),
        .seq_state    (seq_state),
        .err_col      (err_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_prbs  = 7'h7F;
        m_acnt  = 16;
        m_state = 0;
        m_icnt  = 0;
        m_prevt = 1'b0;
    endtask

    task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One column: drive at the negedge, predict, clock, compare just after the edge.
    // xd/xk/xe are the hand-computed output for a non-idle column in DATA.
    task automatic col(input logic [31:0] d, input logic [3:0] c, input logic en,
                       input logic [31:0] xd, input logic [3:0] xk, input logic xe,
                       input string tag);
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        ee;
        bit          idle;
        bit          has_t;
        bit          a_now;
        xgmii_txd = d;
        xgmii_txc = c;
        tx_enable = en;
        idle  = (c == 4'hF) && (d == 32'h0707_0707);
        has_t = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (c[i] && (d[8*i +: 8] == 8'hFD)) has_t = 1'b1;
        end
        a_now = 1'b0;
        ee    = 1'b0;
        ek    = 4'hF;
        if (m_state != 2) begin
            ed = 32'hBCBC_BCBC;
        end else if (idle) begin
            if (m_prevt)            ed = 32'hBCBC_BCBC;
            else if (m_acnt == 0) begin ed = 32'h7C7C_7C7C; a_now = 1'b1; end
            else if (m_prbs[0])     ed = 32'hBCBC_BCBC;
            else                    ed = 32'h1C1C_1C1C;
        end else begin
            ed = xd;
            ek = xk;
            ee = xe;
        end
        if (a_now)           m_acnt = 16 + int'(m_prbs[3:0]);
        else if (m_acnt > 0) m_acnt = m_acnt - 1;
        m_prevt = (m_state == 2) && has_t;
        case (m_state)
            0: if (m_icnt == 15) m_state = 1; else m_icnt = m_icnt + 1;
            1: if (en) m_state = 2;
            default: if (!en) m_state = 1;
        endcase
        m_prbs = {m_prbs[5:0], m_prbs[6] ^ m_prbs[5]};
        @(posedge clk);
        #1;
        check(tag, {enc_data, enc_konstant, seq_state, err_col},
              {ed, ek, 2'(m_state), ee});
        @(negedge clk);
    endtask

    localparam logic [31:0] IDL = 32'h0707_0707;

    int last_a;
    int gap;

    initial begin
        rst_n     = 1'b0;
        xgmii_txd = IDL;
        xgmii_txc = 4'hF;
        tx_enable = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", {enc_data, enc_konstant, seq_state, err_col},
              {32'hBCBC_BCBC, 4'hF, 2'd0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // startup with tx_enable low: ||K|| throughout, INIT then SYNC
        for (int i = 0; i < 15; i++) col(IDL, 4'hF, 1'b0, 32'h0, 4'h0, 1'b0, "init_k");
        check("init_len_15", {37'h0, seq_state}, {37'h0, 2'd0});
        col(IDL, 4'hF, 1'b0, 32'h0, 4'h0, 1'b0, "init_k");
        check("sync_at_16", {37'h0, seq_state}, {37'h0, 2'd1});
        for (int i = 0; i < 4; i++) col(IDL, 4'hF, 1'b0, 32'h0, 4'h0, 1'b0, "sync_k");

        // enable; a_cnt has already run down to 0, so ||Q|| defers the ||A||
        col(IDL, 4'hF, 1'b1, 32'h0, 4'h0, 1'b0, "sync_enable");
        col(32'h0000_009C, 4'h1, 1'b1, 32'h0000_009C, 4'h1, 1'b0, "q_pass");
        col(IDL, 4'hF, 1'b1, 32'h0, 4'h0, 1'b0, "a_after_q");
        check("a_after_q_exact", {enc_data, 7'h0}, {32'h7C7C_7C7C, 7'h0});

        // long idle run: pattern membership and ||A|| spacing
        last_a = 0;
        for (int i = 1; i <= 200; i++) begin
            col(IDL, 4'hF, 1'b1, 32'h0, 4'h0, 1'b0, "idle_run");
            n_tests++;
            assert (((enc_data === 32'h7C7C_7C7C) || (enc_data === 32'hBCBC_BCBC) ||
                     (enc_data === 32'h1C1C_1C1C)) && (enc_konstant === 4'hF)) else begin
                n_fail++;
                $error("FAIL idle_class: got %h/%h expected A/K/R with F", enc_data, enc_konstant);
            end
            if (enc_data === 32'h7C7C_7C7C) begin
                gap = i - last_a - 1;
                n_tests++;
                assert (gap >= 16 && gap <= 31) else begin
                    n_fail++;
                    $error("FAIL a_gap: got %0d expected 16..31", gap);
                end
                last_a = i;
            end
        end

        // start of packet then data
        col(32'h5555_55FB, 4'h1, 1'b1, 32'h5555_55FB, 4'h1, 1'b0, "start_col");
        col(32'h1234_5678, 4'h0, 1'b1, 32'h1234_5678, 4'h0, 1'b0, "data_col");

        // terminate in lane1, trailing /I/ become /K/, then forced ||K||
        col(32'h0707_FD55, 4'hE, 1'b1, 32'hBCBC_FD55, 4'hE, 1'b0, "term_col");
        col(IDL, 4'hF, 1'b1, 32'h0, 4'h0, 1'b0, "k_after_t");
        check("k_after_t_exact", {enc_data, enc_konstant, 3'h0}, {32'hBCBC_BCBC, 4'hF, 3'h0});

        // invalid control on lane0, then err_col drops
        col(32'h0000_0011, 4'h1, 1'b1, 32'h0000_00FE, 4'h1, 1'b1, "invalid_ctrl");
        col(32'hAABB_CCDD, 4'h0, 1'b1, 32'hAABB_CCDD, 4'h0, 1'b0, "err_clear");

        // /I/ before the /T/ lane become /E/
        col(32'h07FD_0707, 4'hF, 1'b1, 32'hBCFD_FEFE, 4'hF, 1'b1, "i_before_t");
        col(IDL, 4'hF, 1'b1, 32'h0, 4'h0, 1'b0, "k_after_t2");

        // disable in DATA: current column translated, then back in SYNC
        col(32'h1122_3344, 4'h0, 1'b0, 32'h1122_3344, 4'h0, 1'b0, "disable_col");
        col(32'h5566_7788, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, "sync_hold");
        col(IDL, 4'hF, 1'b1, 32'h0, 4'h0, 1'b0, "reenable");

        // asynchronous reset in the middle of a packet
        col(32'h5555_55FB, 4'h1, 1'b1, 32'h5555_55FB, 4'h1, 1'b0, "pkt_start2");
        col(32'hDEAD_BEEF, 4'h0, 1'b1, 32'hDEAD_BEEF, 4'h0, 1'b0, "pkt_data2");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {enc_data, enc_konstant, seq_state, err_col},
              {32'hBCBC_BCBC, 4'hF, 2'd0, 1'b0});
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) col(32'hDEAD_BEEF, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0, "reinit_k");
        check("reinit_len_15", {37'h0, seq_state}, {37'h0, 2'd0});
        col(32'hDEAD_BEEF, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0, "reinit_k");
        check("resync_at_16", {37'h0, seq_state}, {37'h0, 2'd1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
